// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
// Shared definitions for the memory-bus controller: CPU command encodings,
// controller FSM states, address-region codes and a counter-width helper.
// Optional feature macro used by the controller: MEM_BUS_FAULT_EN.
// -----------------------------------------------------------------------------
package mem_bus_pkg;

    // CPU command encodings on mem_cmd
    localparam logic [1:0] MNONE    = 2'b00;
    localparam logic [1:0] MREAD    = 2'b01;
    localparam logic [1:0] MWRITE   = 2'b10;
    localparam logic [1:0] MILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RD_WAIT = 2'b01,
        ST_DONE    = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        REG_RAM  = 2'b00,
        REG_LED  = 2'b01,
        REG_SW   = 2'b10,
        REG_NONE = 2'b11
    } region_e;

    // Width of the RAM read-latency down-counter; at least one bit.
    function automatic int unsigned cnt_width(input int unsigned lat);
        if (lat > 32'd1) begin
            return $clog2(lat);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl_if
// CPU-side memory bus: command, address, write payload, read result and the
// completion pulse.
//   master : CPU side   (drives mem_cmd, mem_addr, write_data)
//   slave  : controller (drives read_data, mem_ready)
// -----------------------------------------------------------------------------
interface mem_bus_ctrl_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 16
);
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              mem_ready;

    modport master (
        output mem_cmd,
        output mem_addr,
        output write_data,
        input  read_data,
        input  mem_ready
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        input  write_data,
        output read_data,
        output mem_ready
    );
endinterface

// File: rtl/mem_bus_decode.sv
// -----------------------------------------------------------------------------
// mem_bus_decode
// Combinational address-to-region map over the full address width.
//   i_addr   : CPU address
//   o_region : REG_RAM (addr < RAM_DEPTH), REG_LED, REG_SW or REG_NONE
// -----------------------------------------------------------------------------
module mem_bus_decode
    import mem_bus_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 9,
    parameter int unsigned       RAM_DEPTH = 256,
    parameter logic [ADDR_W-1:0] LED_ADDR  = 9'h100,
    parameter logic [ADDR_W-1:0] SW_ADDR   = 9'h140
) (
    input  logic [ADDR_W-1:0] i_addr,
    output region_e           o_region
);

    // RAM window takes priority so an I/O address placed inside it is shadowed.
    always_comb begin
        o_region = REG_NONE;
        if (32'(i_addr) < RAM_DEPTH) begin
            o_region = REG_RAM;
        end else if (i_addr == LED_ADDR) begin
            o_region = REG_LED;
        end else if (i_addr == SW_ADDR) begin
            o_region = REG_SW;
        end else begin
            o_region = REG_NONE;
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl
// Memory-bus controller between the CPU bus and a synchronous RAM plus a small
// I/O window (LED register, switch input). Every accepted command finishes
// with a one-cycle mem_ready pulse; RAM reads wait RAM_RD_LAT cycles first.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   bus         : CPU bus (mem_bus_ctrl_if.slave)
//   ram_addr    : RAM address (live CPU address in IDLE, latched otherwise)
//   ram_write   : RAM write enable, combinational in the accept cycle
//   ram_din     : RAM write data
//   ram_dout    : RAM read data
//   sw_in       : switch inputs
//   led_out     : LED register
//   bus_fault   : sticky fault flag, only when MEM_BUS_FAULT_EN is defined
// -----------------------------------------------------------------------------
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 9,
    parameter int unsigned       DATA_W     = 16,
    parameter int unsigned       RAM_DEPTH  = 256,
    parameter int unsigned       RAM_AW     = 8,
    parameter int unsigned       RAM_RD_LAT = 1,
    parameter int unsigned       IO_W       = 8,
    parameter logic [ADDR_W-1:0] LED_ADDR   = 9'h100,
    parameter logic [ADDR_W-1:0] SW_ADDR    = 9'h140
) (
    input  logic                clk,
    input  logic                reset,
    mem_bus_ctrl_if.slave       bus,
    output logic [RAM_AW-1:0]   ram_addr,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_din,
    input  logic [DATA_W-1:0]   ram_dout,
    input  logic [IO_W-1:0]     sw_in,
    output logic [IO_W-1:0]     led_out
`ifdef MEM_BUS_FAULT_EN
    ,
    output logic                bus_fault
`endif
);

    localparam int unsigned CNT_W = cnt_width(RAM_RD_LAT);

    state_e              r_state;
    state_e              w_next_state;
    logic [RAM_AW-1:0]   r_addr;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_read_data;
    logic [IO_W-1:0]     r_led;
    region_e             w_region;
    logic                w_accept;
    logic                w_is_read;
    logic                w_is_write;
    logic                w_mem_ready;
    logic                w_ram_write;
    logic [RAM_AW-1:0]   w_ram_addr;

    mem_bus_decode #(
        .ADDR_W    (ADDR_W),
        .RAM_DEPTH (RAM_DEPTH),
        .LED_ADDR  (LED_ADDR),
        .SW_ADDR   (SW_ADDR)
    ) u_decode (
        .i_addr   (bus.mem_addr),
        .o_region (w_region)
    );

    assign w_is_read  = (bus.mem_cmd == MREAD);
    assign w_is_write = (bus.mem_cmd == MWRITE);
    assign w_accept   = (r_state == ST_IDLE) && (bus.mem_cmd != MNONE);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; only a RAM read takes the wait path.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_read && (w_region == REG_RAM)) begin
                    w_next_state = ST_RD_WAIT;
                end else if (w_accept) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RD_WAIT;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs; the RAM sees the live address in IDLE so a latency-1 RAM
    // has its data ready the cycle after accept.
    always_comb begin
        w_mem_ready = (r_state == ST_DONE) && !reset;
        w_ram_write = 1'b0;
        w_ram_addr  = r_addr;
        if (r_state == ST_IDLE) begin
            w_ram_addr  = bus.mem_addr[RAM_AW-1:0];
            w_ram_write = w_is_write && (w_region == REG_RAM) && !reset;
        end else begin
            w_ram_addr  = r_addr;
            w_ram_write = 1'b0;
        end
    end

    // Address latch, latency counter, read-data and LED registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= {RAM_AW{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_read_data <= {DATA_W{1'b0}};
            r_led       <= {IO_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr <= bus.mem_addr[RAM_AW-1:0];
                        if (w_is_read) begin
                            case (w_region)
                                REG_RAM: r_cnt       <= CNT_W'(RAM_RD_LAT - 32'd1);
                                REG_LED: r_read_data <= DATA_W'(r_led);
                                REG_SW:  r_read_data <= DATA_W'(sw_in);
                                default: r_read_data <= {DATA_W{1'b0}};
                            endcase
                        end else if (w_is_write && (w_region == REG_LED)) begin
                            r_led <= bus.write_data[IO_W-1:0];
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (r_cnt == {CNT_W{1'b0}}) begin
                        r_read_data <= ram_dout;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_BUS_FAULT_EN
    logic r_fault;

    // Sticky fault: unmapped access, illegal command or write to the switches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (w_accept && ((bus.mem_cmd == MILLEGAL) || (w_region == REG_NONE) ||
                                  ((w_region == REG_SW) && w_is_write))) begin
            r_fault <= 1'b1;
        end
    end

    assign bus_fault = r_fault;
`endif

    assign bus.read_data = r_read_data;
    assign bus.mem_ready = w_mem_ready;
    assign ram_addr      = w_ram_addr;
    assign ram_write     = w_ram_write;
    assign ram_din       = bus.write_data;
    assign led_out       = r_led;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_ctrl
// Two controllers (RAM read latency 1 and 3) share one RAM storage model and
// are exercised one at a time; `sel` picks the active one. Expected results
// come from a transaction-level model: a word array for RAM, plus LED,
// last-read and fault values per controller.
// Latency is counted in cycles after the accept cycle: 1 for writes and I/O,
// RAM_RD_LAT+1 for RAM reads.
// -----------------------------------------------------------------------------
module tb_mem_bus_ctrl;
    import mem_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [1:0]  b_cmd;
    logic [8:0]  b_addr;
    logic [15:0] b_wdata;
    logic [7:0]  sw_in;

    logic [7:0]  ram_addr1, ram_addr3;
    logic        ram_write1, ram_write3;
    logic [15:0] ram_din1, ram_din3, ram_dout1, ram_dout3;
    logic [7:0]  led1, led3;
`ifdef MEM_BUS_FAULT_EN
    logic        fault1, fault3;
`endif

    int n_checks = 0;
    int n_err    = 0;

    // model state
    logic [15:0] ref_mem [256];
    logic [15:0] exp_rd    [2];
    logic [7:0]  exp_led   [2];
    bit          exp_fault [2];

    always #5 clk = ~clk;

    mem_bus_ctrl_if #(.ADDR_W(9), .DATA_W(16)) if1 ();
    mem_bus_ctrl_if #(.ADDR_W(9), .DATA_W(16)) if3 ();

    assign if1.mem_cmd    = (sel == 1'b0) ? b_cmd : MNONE;
    assign if1.mem_addr   = b_addr;
    assign if1.write_data = b_wdata;
    assign if3.mem_cmd    = (sel == 1'b1) ? b_cmd : MNONE;
    assign if3.mem_addr   = b_addr;
    assign if3.write_data = b_wdata;

    mem_bus_ctrl #(.RAM_RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave),
        .ram_addr(ram_addr1), .ram_write(ram_write1), .ram_din(ram_din1),
        .ram_dout(ram_dout1), .sw_in(sw_in), .led_out(led1)
`ifdef MEM_BUS_FAULT_EN
        , .bus_fault(fault1)
`endif
    );

    mem_bus_ctrl #(.RAM_RD_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .bus(if3.slave),
        .ram_addr(ram_addr3), .ram_write(ram_write3), .ram_din(ram_din3),
        .ram_dout(ram_dout3), .sw_in(sw_in), .led_out(led3)
`ifdef MEM_BUS_FAULT_EN
        , .bus_fault(fault3)
`endif
    );

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 257) ^ 16'h5A5A;
    endfunction

    // Synchronous RAM: shared storage, 1-stage and 3-stage read pipelines.
    logic [15:0] ram_mem [256];
    logic [15:0] pipe1;
    logic [15:0] pipe3 [3];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i);
        end else begin
            if (ram_write1) ram_mem[ram_addr1] <= ram_din1;
            if (ram_write3) ram_mem[ram_addr3] <= ram_din3;
        end
        pipe1    <= ram_mem[ram_addr1];
        pipe3[0] <= ram_mem[ram_addr3];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign ram_dout1 = pipe1;
    assign ram_dout3 = pipe3[2];

    // view of the selected controller
    logic        m_ready, m_ram_write;
    logic [15:0] m_rdata;
    logic [7:0]  m_ram_addr, m_led;
    assign m_ready     = sel ? if3.mem_ready : if1.mem_ready;
    assign m_rdata     = sel ? if3.read_data : if1.read_data;
    assign m_ram_write = sel ? ram_write3 : ram_write1;
    assign m_ram_addr  = sel ? ram_addr3 : ram_addr1;
    assign m_led       = sel ? led3 : led1;
`ifdef MEM_BUS_FAULT_EN
    logic m_fault;
    assign m_fault = sel ? fault3 : fault1;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        for (int k = 0; k < 2; k++) begin
            exp_rd[k] = 16'h0000; exp_led[k] = 8'h00; exp_fault[k] = 1'b0;
        end
    endtask

    // Drive one command starting in an IDLE cycle (shortly after a rising
    // edge) and hold it until mem_ready; returns in the cycle after DONE.
    task automatic run_txn(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd,
                           output int lat, output logic [15:0] rd, output int nwr, output bit stable);
        lat = 0; nwr = 0; stable = 1'b1; rd = 16'h0000;
        b_cmd = cmd; b_addr = addr; b_wdata = wd;
        #1;
        if (m_ram_write === 1'b1) nwr++;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (m_ram_write === 1'b1) nwr++;
            if (m_ram_addr !== addr[7:0]) stable = 1'b0;
            if (m_ready === 1'b1) begin
                lat = c;
                rd  = m_rdata;
            end
        end
        b_cmd = MNONE;
        @(posedge clk); #1;
    endtask

    task automatic txn_check(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd,
                             output int lat, output logic [15:0] rd);
        bit is_ram, is_led, is_sw, is_rd, is_wr, stable;
        int exp_lat, nwr;
        is_ram  = (int'(addr) < 256);
        is_led  = (addr == 9'h100);
        is_sw   = (addr == 9'h140);
        is_rd   = (cmd == MREAD);
        is_wr   = (cmd == MWRITE);
        exp_lat = (is_rd && is_ram) ? ((sel ? 3 : 1) + 1) : 1;
        run_txn(cmd, addr, wd, lat, rd, nwr, stable);
        if (is_rd) begin
            if (is_ram)      exp_rd[sel] = ref_mem[addr[7:0]];
            else if (is_led) exp_rd[sel] = {8'h00, exp_led[sel]};
            else if (is_sw)  exp_rd[sel] = {8'h00, sw_in};
            else             exp_rd[sel] = 16'h0000;
        end
        if (is_wr && is_ram) ref_mem[addr[7:0]] = wd;
        if (is_wr && is_led) exp_led[sel] = wd[7:0];
        if ((cmd == MILLEGAL) || !(is_ram || is_led || is_sw) || (is_sw && is_wr)) exp_fault[sel] = 1'b1;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("read_data", 32'(rd), 32'(exp_rd[sel]));
        chk("ram_write_cycles", 32'(nwr), (is_wr && is_ram) ? 32'd1 : 32'd0);
        chk("ram_addr_hold", 32'(stable), 32'd1);
        chk("led_out", 32'(m_led), 32'(exp_led[sel]));
        chk("ready_single_cycle", 32'(m_ready), 32'd0);
`ifdef MEM_BUS_FAULT_EN
        chk("bus_fault", 32'(m_fault), 32'(exp_fault[sel]));
`endif
    endtask

    initial begin
        int lat;
        int rdy_cnt;
        logic [15:0] rd;
        logic [1:0]  cmd;
        logic [8:0]  addr;

        // reset with a RAM write pending: write enable must stay low
        reset = 1'b1; sel = 1'b0; sw_in = 8'h00;
        b_cmd = MWRITE; b_addr = 9'h005; b_wdata = 16'hFFFF;
        model_reset();
        @(posedge clk); #1;
        chk("ram_write_in_reset", 32'(ram_write1), 32'd0);
        @(posedge clk); #1;
        chk("ram_write_in_reset2", 32'(ram_write1), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; b_cmd = MNONE;
        #1;
        chk("rst_read_data1", 32'(if1.read_data), 32'd0);
        chk("rst_ready1", 32'(if1.mem_ready), 32'd0);
        chk("rst_led1", 32'(led1), 32'd0);
        chk("rst_read_data3", 32'(if3.read_data), 32'd0);
        chk("rst_ready3", 32'(if3.mem_ready), 32'd0);
        chk("rst_led3", 32'(led3), 32'd0);
`ifdef MEM_BUS_FAULT_EN
        chk("rst_fault1", 32'(fault1), 32'd0);
        chk("rst_fault3", 32'(fault3), 32'd0);
`endif

        // latency-1 controller: RAM write/read, I/O, unmapped
        sel = 1'b0;
        txn_check(MWRITE, 9'h005, 16'hABCD, lat, rd);
        txn_check(MREAD, 9'h005, 16'h0000, lat, rd);
        chk("ram_read_abcd", 32'(rd), 32'h0000ABCD);
        chk("ram_read_lat1", 32'(lat), 32'd2);
        txn_check(MWRITE, 9'h100, 16'h00A5, lat, rd);
        chk("led_a5", 32'(led1), 32'h000000A5);
        txn_check(MREAD, 9'h100, 16'h0000, lat, rd);
        chk("led_read", 32'(rd), 32'h000000A5);
        sw_in = 8'h3C;
        txn_check(MREAD, 9'h140, 16'h0000, lat, rd);
        chk("sw_read", 32'(rd), 32'h0000003C);
        txn_check(MREAD, 9'h1FF, 16'h0000, lat, rd);
        chk("unmapped_read", 32'(rd), 32'd0);
        chk("unmapped_lat", 32'(lat), 32'd1);
        txn_check(MWRITE, 9'h140, 16'hFFFF, lat, rd);
        txn_check(MILLEGAL, 9'h007, 16'h1234, lat, rd);
        txn_check(MREAD, 9'h007, 16'h0000, lat, rd);

        // latency-3 controller
        sel = 1'b1;
        txn_check(MREAD, 9'h010, 16'h0000, lat, rd);
        chk("ram_read_lat3", 32'(lat), 32'd4);
        chk("ram_read_10", 32'(rd), 32'(init_word(16)));

        // randomized traffic on both controllers
        for (int n = 0; n < 80; n++) begin
            sel   = 1'($urandom_range(0, 1));
            cmd   = 2'($urandom_range(1, 3));
            sw_in = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       addr = 9'($urandom_range(0, 255));
                1:       addr = 9'h100;
                2:       addr = 9'h140;
                default: addr = 9'($urandom_range(256, 511));
            endcase
            txn_check(cmd, addr, 16'($urandom), lat, rd);
        end

        // reset during RD_WAIT on the latency-3 controller
        sel = 1'b1;
        txn_check(MWRITE, 9'h100, 16'h005A, lat, rd);
        txn_check(MREAD, 9'h1FF, 16'h0000, lat, rd);
        b_cmd = MREAD; b_addr = 9'h020;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort_no_ready", 32'(if3.mem_ready), 32'd0);
        chk("abort_read_data_kept", 32'(if3.read_data), 32'(exp_rd[1]));
        @(posedge clk); #1;
        reset = 1'b0; b_cmd = MNONE;
        model_reset();
        #1;
        chk("post_rst_ready", 32'(if3.mem_ready), 32'd0);
        chk("post_rst_read_data", 32'(if3.read_data), 32'd0);
        chk("post_rst_led", 32'(led3), 32'd0);
        chk("post_rst_ram_write", 32'(ram_write3), 32'd0);
`ifdef MEM_BUS_FAULT_EN
        chk("post_rst_fault", 32'(fault3), 32'd0);
`endif
        rdy_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (if3.mem_ready !== 1'b0) rdy_cnt++;
        end
        chk("aborted_ready_count", 32'(rdy_cnt), 32'd0);

        // both controllers usable again after reset
        txn_check(MWRITE, 9'h033, 16'h1357, lat, rd);
        txn_check(MREAD, 9'h033, 16'h0000, lat, rd);
        chk("post_rst_ram_read", 32'(rd), 32'h00001357);
        sel = 1'b0;
        txn_check(MREAD, 9'h005, 16'h0000, lat, rd);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
